riscv_lsu_ctrl: RTL
===================

RISCV_LSU_CTRL -- requirements
Module: riscv_lsu_ctrl

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 core_req_i  in  1  core requests a load/store this cycle (decoder mem_req).
REQ-004 core_we_i  in  1  1 = store, 0 = load (decoder mem_we).
REQ-005 core_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5 (decoder mem_size).
REQ-006 core_addr_i  in  32  byte address from ALU result.
REQ-007 core_wd_i  in  32  store data (rs2).
REQ-008 core_rd_o  out  32  formatted load result, valid in DONE.
REQ-009 core_stall_o  out  1  holds core PC/pipeline while access in progress.
REQ-010 core_err_o  out  1  one-cycle pulse: misaligned or illegal-size access, no memory access made.
REQ-011 mem_req_o, mem_we_o  out  1 each  data-memory request and write enable.
REQ-012 mem_be_o  out  4  byte enables; mem_addr_o out 32 word address {addr[31:2],2'b00}; mem_wd_o out 32 lane-replicated write data.
REQ-013 mem_rd_i  in  32  read word; mem_ready_i in 1 access complete this cycle.

Function
REQ-014 FSM states IDLE, REQ, DONE; encoding free.
REQ-015 IDLE: core_req_i=1 and legal -> latch we/size/addr[1:0]/be/addr/wd, go REQ; else stay IDLE.
REQ-016 Illegal: size in {3,6,7}; store with size 4/5; H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-017 Illegal request in IDLE: core_err_o=1 same cycle (combinational), core_stall_o=0, no mem_req_o, stay IDLE.
REQ-018 REQ: mem_req_o=1 with latched mem_we_o/mem_be_o/mem_addr_o/mem_wd_o, held stable until mem_ready_i=1.
REQ-019 REQ and mem_ready_i=1: load -> register formatted mem_rd_i into core_rd_o; store -> core_rd_o unchanged; go DONE.
REQ-020 DONE: mem_req_o=0, core_stall_o=0 for exactly one cycle, then IDLE unconditionally; core_req_i not sampled in DONE.
REQ-021 core_stall_o = core_req_i & legal in IDLE; 1 in REQ; 0 in DONE.
REQ-022 Minimum latency: request cycle N, mem_req_o cycle N+1, ready in N+1 -> DONE N+2 (3 cycles total, 2 stalled).
REQ-023 mem_ready_i ignored outside REQ.
REQ-024 core_req_i dropped during REQ: access still completes, then DONE, then IDLE.
REQ-025 Byte enables: B -> 4'b0001<<addr[1:0]; H -> addr[1]?4'b1100:4'b0011; W -> 4'b1111; loads use same be.
REQ-026 Store data: B -> {4{wd[7:0]}}; H -> {2{wd[15:0]}}; W -> wd.
REQ-027 Load format: B/BU select byte mem_rd_i[8*addr[1:0]+:8], H/HU select half mem_rd_i[16*addr[1]+:16]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-028 core_rd_o is a register; holds last load value until next load completes.

Reset
REQ-029 rst_ni=0 forces IDLE immediately; all outputs 0 (core_rd_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0).
REQ-030 Reset mid-REQ abandons the access; no completion, no DONE after release.
REQ-031 First request accepted on first rising edge with rst_ni=1.

Verification
REQ-032 LW addr 0x100, ready in first REQ cycle, mem_rd_i=0xDEADBEEF -> mem_req_o 1 cycle, be=1111, addr 0x100, stall 2 cycles, core_rd_o=0xDEADBEEF.
REQ-033 LB addr 0x203, mem_rd_i=0x80FF0011 -> be=1000, core_rd_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x000080FF.
REQ-034 SH addr 0x22, wd=0x1234ABCD, ready after 3 wait cycles -> mem_we_o=1, be=1100, wd=0xABCDABCD, outputs stable 4 REQ cycles, stall 5 cycles.
REQ-035 LW addr 0x101; SH addr 0x23; size 3; SB with size 4 -> core_err_o pulse, stall 0, mem_req_o never asserted.
REQ-036 rst_ni low during REQ with mem_ready_i=0 -> outputs 0 at once; after release, mem_ready_i=1 causes no DONE, next LW proceeds normally.
REQ-037 Back-to-back SW then LW on consecutive accepts -> second request accepted the cycle after DONE, no lost or duplicated mem_req_o.

Source files
------------

// File: rtl/riscv_lsu_ctrl.sv
// rtl/riscv_lsu_ctrl.sv - RISC-V load/store unit controller: alignment check, lane steering, load formatting
module riscv_lsu_ctrl (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t      state;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic        legal;
    logic [3:0]  be_next;
    logic [31:0] wd_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        legal = 1'b0;
        case (core_size_i)
            LDST_B:  legal = 1'b1;
            LDST_H:  legal = ~core_addr_i[0];
            LDST_W:  legal = (core_addr_i[1:0] == 2'b00);
            LDST_BU: legal = ~core_we_i;
            LDST_HU: legal = ~core_we_i & ~core_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    // Unsigned variants share lane steering with their signed twins via size[1:0].
    always_comb begin
        be_next = 4'b1111;
        wd_next = core_wd_i;
        case (core_size_i[1:0])
            2'd0: begin
                be_next = 4'b0001 << core_addr_i[1:0];
                wd_next = {4{core_wd_i[7:0]}};
            end
            2'd1: begin
                be_next = core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_next = {2{core_wd_i[15:0]}};
            end
            default: begin
                be_next = 4'b1111;
                wd_next = core_wd_i;
            end
        endcase
    end

    assign byte_sel = mem_rd_i[{off_q, 3'b000} +: 8];
    assign half_sel = mem_rd_i[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = mem_rd_i;
        case (size_q)
            LDST_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: load_data = {24'd0, byte_sel};
            LDST_H:  load_data = {{16{half_sel[15]}}, half_sel};
            LDST_HU: load_data = {16'd0, half_sel};
            default: load_data = mem_rd_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            size_q     <= 3'd0;
            off_q      <= 2'd0;
            core_rd_o  <= 32'd0;
            mem_we_o   <= 1'b0;
            mem_be_o   <= 4'd0;
            mem_addr_o <= 32'd0;
            mem_wd_o   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (core_req_i && legal) begin
                        size_q     <= core_size_i;
                        off_q      <= core_addr_i[1:0];
                        mem_we_o   <= core_we_i;
                        mem_be_o   <= be_next;
                        mem_addr_o <= {core_addr_i[31:2], 2'b00};
                        mem_wd_o   <= wd_next;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        if (!mem_we_o) core_rd_o <= load_data;
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stall and error are combinational in IDLE, so they are gated by reset to keep all outputs low.
    assign mem_req_o    = (state == S_REQ);
    assign core_stall_o = rst_ni & (((state == S_IDLE) & core_req_i & legal) | (state == S_REQ));
    assign core_err_o   = rst_ni & (state == S_IDLE) & core_req_i & ~legal;

endmodule
